// File: rtl/fn_sw_pkg.sv
// Shared types and constants for the fn_sw stimulus sequencer.
// Imported by the sequencer and by its benches.
package fn_sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         NUM_VEC  = 8;
    localparam logic [2:0] LAST_VEC = 3'd7;

endpackage

// File: rtl/fn_sw_seq_if.sv
// Operand/result bus between the sequencer and fn_sw.
// master drives the operands, slave returns y.
interface fn_sw_seq_if;

    logic a;
    logic b;
    logic sel;
    logic y;

    modport master (
        output a,
        output b,
        output sel,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        input  sel,
        output y
    );

endinterface

// File: rtl/fn_sw_golden.sv
// Combinational reference for fn_sw: xor when sel, and otherwise.
// Kept standalone so later benches can reuse it.
module fn_sw_golden (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic exp_y
);

    assign exp_y = sel ? (a ^ b) : (a & b);

endmodule

// File: rtl/fn_sw_seq.sv
// Sweeps fn_sw through all 8 input vectors and self-checks y.
// Reports error count, first failing vector and a pass flag.
module fn_sw_seq
    import fn_sw_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int HW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    fn_sw_seq_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [3:0]  err_cnt,
    output logic [2:0]  first_fail,
    output logic        fail_seen,
    output logic        pass
);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    vec;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    drv;
    logic          exp_y;
    logic          sample;
    logic          mismatch;

    assign bus.a   = drv[2];
    assign bus.b   = drv[1];
    assign bus.sel = drv[0];

    fn_sw_golden u_golden (
        .a     (drv[2]),
        .b     (drv[1]),
        .sel   (drv[0]),
        .exp_y (exp_y)
    );

    assign sample   = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
    assign mismatch = sample && (bus.y != exp_y);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status strobes
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (sample && vec == LAST_VEC) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Vector walk, hold timing and result scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            hold_cnt   <= '0;
            drv        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    drv <= '0;
                    if (start) begin
                        vec        <= '0;
                        hold_cnt   <= '0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (sample) begin
                        hold_cnt <= '0;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 4'd1;
                            if (!fail_seen) begin
                                first_fail <= vec;
                                fail_seen  <= 1'b1;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            drv <= '0;
                        end else begin
                            vec <= vec + 3'd1;
                            drv <= vec + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    drv  <= '0;
                    pass <= (err_cnt == 4'd0);
                end
                default: begin
                    drv <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fn_sw_seq.sv
// Bench for fn_sw_seq: directed and random sweeps on HOLD=4 and
// HOLD=1 instances, with y served from a per-vector lookup table.
module tb_fn_sw_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, rst1, start4, start1;
    logic [7:0] tab;
    logic       use1;

    logic       busy4, done4, fs4, pass4;
    logic [3:0] err4;
    logic [2:0] ff4;
    logic       busy1, done1, fs1, pass1;
    logic [3:0] err1;
    logic [2:0] ff1;

    fn_sw_seq_if if4 ();
    fn_sw_seq_if if1 ();

    assign if4.y = tab[{if4.a, if4.b, if4.sel}];
    assign if1.y = tab[{if1.a, if1.b, if1.sel}];

    fn_sw_seq #(.HOLD(4), .HW(4)) d4 (
        .clk        (clk),
        .rst        (rst4),
        .start      (start4),
        .bus        (if4),
        .busy       (busy4),
        .done       (done4),
        .err_cnt    (err4),
        .first_fail (ff4),
        .fail_seen  (fs4),
        .pass       (pass4)
    );

    fn_sw_seq #(.HOLD(1), .HW(4)) d1 (
        .clk        (clk),
        .rst        (rst1),
        .start      (start1),
        .bus        (if1),
        .busy       (busy1),
        .done       (done1),
        .err_cnt    (err1),
        .first_fail (ff1),
        .fail_seen  (fs1),
        .pass       (pass1)
    );

    logic       m_busy, m_done, m_fs, m_pass;
    logic [3:0] m_err;
    logic [2:0] m_ff, m_abs;

    always_comb begin
        m_busy = use1 ? busy1 : busy4;
        m_done = use1 ? done1 : done4;
        m_fs   = use1 ? fs1 : fs4;
        m_pass = use1 ? pass1 : pass4;
        m_err  = use1 ? err1 : err4;
        m_ff   = use1 ? ff1 : ff4;
        m_abs  = use1 ? {if1.a, if1.b, if1.sel}
                      : {if4.a, if4.b, if4.sel};
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Spec rule: y = sel ? a^b : a&b, index = {a,b,sel}
    function automatic logic gold(int idx);
        logic av, bv, sv;
        av = ((idx >> 2) & 1) != 0;
        bv = ((idx >> 1) & 1) != 0;
        sv = (idx & 1) != 0;
        return sv ? (av ^ bv) : (av & bv);
    endfunction

    function automatic logic [7:0] good_tab();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = gold(i);
        return t;
    endfunction

    function automatic int model_err(logic [7:0] t);
        int n = 0;
        for (int i = 0; i < 8; i++)
            if (t[i] !== gold(i)) n++;
        return n;
    endfunction

    function automatic int model_first(logic [7:0] t);
        for (int i = 0; i < 8; i++)
            if (t[i] !== gold(i)) return i;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d",
                    tag, obs, exp);
    endtask

    task automatic sel_dut(logic v);
        use1 = v;
        #1;
    endtask

    task automatic set_start(logic v);
        if (use1) start1 = v;
        else start4 = v;
    endtask

    task automatic run_sweep(int h, int restart_at);
        int  cnt;
        bit  trace_ok;
        cnt      = 0;
        trace_ok = 1'b1;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("clr_err", 32'(m_err), 0);
        chk("clr_fs", 32'(m_fs), 0);
        chk("clr_pass", 32'(m_pass), 0);
        while (m_busy === 1'b1 && cnt < 400) begin
            if (m_abs !== 3'(cnt / h)) trace_ok = 1'b0;
            set_start(cnt == restart_at);
            cnt++;
            @(negedge clk);
        end
        set_start(1'b0);
        chk("busy_len", cnt, 8 * h);
        chk("trace", 32'(trace_ok), 1);
        chk("done_pulse", 32'(m_done), 1);
        chk("abs_done", 32'(m_abs), 0);
        @(negedge clk);
        chk("done_once", 32'(m_done), 0);
        chk("idle_busy", 32'(m_busy), 0);
    endtask

    task automatic check_res();
        int e;
        e = model_err(tab);
        chk("err_cnt", 32'(m_err), e);
        chk("first_fail", 32'(m_ff), model_first(tab));
        chk("fail_seen", 32'(m_fs), (e > 0) ? 1 : 0);
        chk("pass", 32'(m_pass), (e == 0) ? 1 : 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done"}, 32'(m_done), 0);
        chk({tag, "_abs"}, 32'(m_abs), 0);
        chk({tag, "_err"}, 32'(m_err), 0);
        chk({tag, "_ff"}, 32'(m_ff), 0);
        chk({tag, "_fs"}, 32'(m_fs), 0);
        chk({tag, "_pass"}, 32'(m_pass), 0);
    endtask

    initial begin
        int t, t1;
        rst4   = 1'b1;
        rst1   = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        use1   = 1'b0;
        tab    = good_tab();
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        sel_dut(1'b0);
        check_zero("rst4");
        sel_dut(1'b1);
        check_zero("rst1");

        // 1: correct fn_sw, HOLD=4
        sel_dut(1'b0);
        tab = good_tab();
        run_sweep(4, -1);
        check_res();

        // 2: y tied low
        tab = 8'h00;
        run_sweep(4, -1);
        check_res();
        chk("t2_ff", 32'(m_ff), 3);

        // 3: inverted fn_sw, HOLD=1
        sel_dut(1'b1);
        tab = ~good_tab();
        run_sweep(1, -1);
        check_res();
        chk("t3_err", 32'(m_err), 8);

        // 4: start during vector 3 is ignored
        sel_dut(1'b0);
        tab = good_tab();
        run_sweep(4, 3 * 4 + 1);
        check_res();
        repeat (3) begin
            @(negedge clk);
            chk("no_requeue", 32'(m_busy), 0);
        end
        tab = 8'h00;
        run_sweep(4, -1);
        tab = good_tab();
        run_sweep(4, -1);
        check_res();

        // 5: reset mid-sweep with y tied high
        tab = 8'hff;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (5 * 4) @(negedge clk);
        chk("at_vec5", 32'(m_abs), 5);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_idle", 32'({m_busy, m_done}), 0);
        end
        run_sweep(4, -1);
        check_res();
        chk("t5_err", 32'(m_err), 5);

        // 6: start held high, back-to-back sweeps
        tab = good_tab();
        set_start(1'b1);
        t = 0;
        while (m_done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t6_done1", 32'(m_done), 1);
        chk("t6_abs_done", 32'(m_abs), 0);
        t1 = t;
        @(negedge clk);
        t++;
        chk("t6_abs_idle", 32'(m_abs), 0);
        chk("t6_busy_idle", 32'(m_busy), 0);
        while (m_done !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("t6_done2", 32'(m_done), 1);
        chk("t6_gap", t - t1, 8 * 4 + 2);
        chk("t6_abs_done2", 32'(m_abs), 0);
        set_start(1'b0);
        @(negedge clk);
        chk("t6_abs_idle2", 32'(m_abs), 0);
        @(negedge clk);
        chk("t6_stop", 32'(m_busy), 0);

        // random fault tables on either instance
        repeat (6) begin
            sel_dut(1'($urandom_range(0, 1)));
            tab = 8'($urandom);
            run_sweep(use1 ? 1 : 4, -1);
            check_res();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fn_sw_seq.md
Name: fn_sw_seq

Overview:
- Upstream stimulus sequencer for the fn_sw 2:1 function selector.
- On a start pulse it drives (a, b, sel) through all 8 input combinations in ascending order, holding each one for a programmable number of cycles.
- On the last hold cycle of each vector it samples the selector's y output and checks it against y = sel ? (a ^ b) : (a & b).
- It reports an error count, the first failing vector and a pass flag, so fn_sw can be checked on-chip without a testbench.

Parameters:
- HOLD, 4: cycles each vector is held; legal range 1..2**HW-1.
- HW, 4: width of the hold counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; acted on only in IDLE.
- y  in  1  result from fn_sw; combinational from a/b/sel.
- a  out  1  operand a to fn_sw; registered.
- b  out  1  operand b to fn_sw; registered.
- sel  out  1  function select to fn_sw; registered.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- err_cnt  out  4  number of mismatching vectors in the last sweep (0..8).
- first_fail  out  3  index {a,b,sel} of the first mismatch; valid when fail_seen=1.
- fail_seen  out  1  at least one mismatch in the last sweep.
- pass  out  1  last sweep completed with err_cnt==0.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high, applied on a clk edge with rst=1.
  - Reset overrides every other input, including mid-sweep: the sweep is abandoned with no done pulse.
  - After reset all outputs are 0 and the state is IDLE.
- State machine, three states: IDLE, RUN, DONE.
- IDLE:
  - a=b=sel=0 and busy=0.
  - Result outputs keep the values from the last sweep.
  - When start=1, on the next edge: state=RUN, vec=0, hold_cnt=0, err_cnt=0, fail_seen=0, first_fail=0, pass=0.
- RUN:
  - busy=1.
  - {a,b,sel} = vec, with vec[2]=a, vec[1]=b, vec[0]=sel.
  - hold_cnt increments each cycle.
- Sample point: the cycle where hold_cnt==HOLD-1.
  - expected = sel ? (a^b) : (a&b), computed from the registered outputs.
  - If y != expected:
    - err_cnt increments.
    - If fail_seen=0, first_fail=vec and fail_seen=1 on the same edge.
    - Only the first mismatch is latched.
  - On the same edge hold_cnt returns to 0.
  - If vec<7: vec increments.
  - If vec==7: the next state is DONE.
- DONE: lasts one cycle.
  - done=1, busy=0, a=b=sel=0.
  - pass = (err_cnt==0). pass is registered on the DONE edge, so it reads 1 from the first IDLE cycle onwards.
  - Next state is IDLE unconditionally.
- Timing: if start is seen at edge E0, busy is high for exactly 8*HOLD cycles and done pulses in the cycle after the last sample.
- start handling:
  - start in RUN or DONE is ignored. It is neither queued nor allowed to restart the sweep.
  - start held high continuously produces back-to-back sweeps, with one IDLE cycle after each DONE.
- Arithmetic: err_cnt saturates naturally at 8, since it can never exceed 8. No wrap is possible.
- HOLD=1: every RUN cycle is a sample cycle. The sweep lasts 8 cycles.
- y is sampled only at sample points. Glitches or X on y at other times have no effect.

Decomposition:
- Package fn_sw_pkg holds:
  - the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NUM_VEC=8;
  - LAST_VEC=3'd7.
- One sub-module, fn_sw_golden: a purely combinational expected-value model with inputs (a, b, sel) and output exp_y.
  - It is instantiated once inside fn_sw_seq.
  - It is reusable by later testbenches.

Test Plan:
1. Correct fn_sw, HOLD=4. Reset, then a start pulse.
   - Required: busy high for 32 cycles, then one done pulse.
   - Required: a/b/sel walk 000..111, each held 4 cycles.
   - Required: err_cnt=0, fail_seen=0, pass=1.
2. y tied to 0, HOLD=4. Start.
   - Required: the mismatches are vectors 3, 5 and 6.
   - Required: err_cnt=3, first_fail=3, fail_seen=1, pass=0.
3. y driven as the inverse of correct fn_sw, HOLD=1. Start.
   - Required: busy for exactly 8 cycles.
   - Required: err_cnt=8, first_fail=0, pass=0.
4. Correct fn_sw. Pulse start again at vector 3 of a sweep.
   - Required: the second start is ignored, with a single sweep of 8*HOLD cycles and one done pulse.
   - Then pulse start in IDLE. Required: a new sweep starts with err_cnt cleared to 0.
5. y tied to 1. Assert rst for one cycle during vector 5.
   - Required: next cycle all outputs are 0, state is IDLE and there is no done pulse.
   - Then start. Required: a full sweep giving err_cnt=5 (vectors 0, 1, 2, 4, 7) and first_fail=0.
6. start held high across 2 sweeps.
   - Required: two done pulses exactly 8*HOLD+2 cycles apart.
   - Required: a/b/sel=0 during the intervening DONE and IDLE cycles.
